// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative multiply/divide unit.
//   DEFAULT_WIDTH : default operand and HI/LO width
//   OP_*          : 3-bit operation codes (6 and 7 reserved)
//   state_e       : FSM state encoding (IDLE, RUN, FIXUP)
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the {acc, qr} register pair.
//   Multiply : right-shifting shift/add; {acc,qr} becomes the 2*WIDTH product
//              after WIDTH steps (qr starts as the multiplier, m is the
//              multiplicand).
//   Divide   : left-shifting restoring divide; qr starts as the dividend and
//              collects quotient bits, acc collects the remainder (m = divisor).
// Ports:
//   is_div_i : select divide step (present only with MULDIV_DIVIDE_EN)
//   acc_i/qr_i/m_i : current iteration registers
//   acc_o/qr_o     : next iteration registers
// Macro MULDIV_DIVIDE_EN adds the divide datapath.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MULDIV_DIVIDE_EN
  input  logic             is_div_i,
`endif
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] qr_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] qr_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc_i} + (qr_i[0] ? {1'b0, m_i} : '0);

`ifdef MULDIV_DIVIDE_EN
  logic [WIDTH:0] rem;
  logic           ge;

  // Partial remainder after shifting in the next dividend bit; it can need
  // WIDTH+1 bits, but the difference always fits in WIDTH when ge is set.
  assign rem = {acc_i, qr_i[WIDTH-1]};
  assign ge  = (rem >= {1'b0, m_i});
`endif

  always_comb begin
    acc_o = sum[WIDTH:1];
    qr_o  = {sum[0], qr_i[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
    if (is_div_i) begin
      acc_o = ge ? (rem[WIDTH-1:0] - m_i) : rem[WIDTH-1:0];
      qr_o  = {qr_i[WIDTH-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (radix-2, WIDTH cycles).
// Ports:
//   clock, reset (async, active-low)
//   start, op[2:0], operand_a, operand_b : request, sampled while idle
//   cancel      : flush; aborts the operation in flight, drops an idle start
//   busy        : high while an iterative operation runs (RUN/FIXUP)
//   done        : one-cycle pulse once hi/lo hold the new result
//   hi, lo      : HI/LO registers
//   div_by_zero : valid with done; last divide had a zero divisor
// Macro MULDIV_DIVIDE_EN enables DIV/DIVU; without it they act as reserved
// ops and div_by_zero is tied low.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               neg_res_q, neg_res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_acc, step_qr;
  logic               op_signed, long_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_DIVIDE_EN
  logic               is_div_q, is_div_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic               dbz_q, dbz_d;
  logic               div_op;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign div_op   = (op == OP_DIV) || (op == OP_DIVU);
  assign long_op  = (op == OP_MULT) || (op == OP_MULTU) || div_op;
  assign quot_fix = neg_res_q ? -qr_q : qr_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;
`else
  assign long_op  = (op == OP_MULT) || (op == OP_MULTU);
`endif

  // Signed ops iterate on magnitudes; the sign is restored in FIXUP.
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed && operand_a[WIDTH-1];
  assign b_neg     = op_signed && operand_b[WIDTH-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign prod_fix  = neg_res_q ? -{acc_q, qr_q} : {acc_q, qr_q};

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
`ifdef MULDIV_DIVIDE_EN
    .is_div_i (is_div_q),
`endif
    .acc_i    (acc_q),
    .qr_i     (qr_q),
    .m_i      (m_q),
    .acc_o    (step_acc),
    .qr_o     (step_qr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    m_d       = m_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIVIDE_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    dbz_d     = dbz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (long_op) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            acc_d     = '0;
            neg_res_d = a_neg ^ b_neg;
            qr_d      = b_mag;
            m_d       = a_mag;
`ifdef MULDIV_DIVIDE_EN
            is_div_d  = div_op;
            neg_rem_d = a_neg;
            bzero_d   = (operand_b == '0);
            if (div_op) begin
              qr_d = a_mag;
              m_d  = b_mag;
            end
`endif
          end else begin
            done_d = 1'b1;
            if (op == OP_MTHI) hi_d = operand_a;
            if (op == OP_MTLO) lo_d = operand_a;
`ifdef MULDIV_DIVIDE_EN
            if ((op == OP_MTHI) || (op == OP_MTLO)) dbz_d = 1'b0;
`endif
          end
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          qr_d  = step_qr;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          hi_d   = prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
          dbz_d  = 1'b0;
          if (is_div_q) begin
            // A zero divisor leaves |dividend| in acc, so the signed
            // remainder fix-up already yields operand_a; only lo needs forcing.
            hi_d  = rem_fix;
            lo_d  = bzero_q ? '1 : quot_fix;
            dbz_d = bzero_q;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      m_q       <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      qr_q      <= qr_d;
      m_q       <= m_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULDIV_DIVIDE_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIVIDE_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
